yuv444_to_422: RTL and testbench

YUV444_TO_422 -- requirements
Module: yuv444_to_422

---
 rtl/yuv444_to_422.sv | 180 ++++++++++++++++++
 tb/tb_yuv444_to_422.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/yuv444_to_422.sv
// 4:4:4 to 4:2:2 chroma decimator: pairs pixels and averages their chroma.
// Emits Cb then Cr words through a first-word-fall-through output FIFO.
module yuv444_to_422 #(
  parameter int DATA_W     = 10,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          Clock,
  input  logic                          Reset,
  input  logic [DATA_W-1:0]             Y_in,
  input  logic [DATA_W-1:0]             Cb_in,
  input  logic [DATA_W-1:0]             Cr_in,
  input  logic                          data_valid_in,
  input  logic                          line_start,
  output logic [2*DATA_W-1:0]           out_data,
  output logic                          out_is_cr,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int WW = 2*DATA_W + 1;

  typedef enum logic {
    EVEN = 1'b0,
    ODD  = 1'b1
  } phase_e;

  phase_e phase;
  phase_e phase_nxt;
  logic   capture;
  logic   pair;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      phase <= EVEN;
    end else begin
      phase <= phase_nxt;
    end
  end

  always_comb begin
    phase_nxt = phase;
    if (data_valid_in) begin
      unique case (1'b1)
        (line_start || phase == EVEN): phase_nxt = ODD;
        default:                       phase_nxt = EVEN;
      endcase
    end
  end

  always_comb begin
    capture = 1'b0;
    pair    = 1'b0;
    if (data_valid_in) begin
      unique case (1'b1)
        (line_start || phase == EVEN): capture = 1'b1;
        default:                       pair    = 1'b1;
      endcase
    end
  end

  logic [DATA_W-1:0] y0;
  logic [DATA_W-1:0] cb0;
  logic [DATA_W-1:0] cr0;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      y0  <= '0;
      cb0 <= '0;
      cr0 <= '0;
    end else if (capture) begin
      y0  <= Y_in;
      cb0 <= Cb_in;
      cr0 <= Cr_in;
    end
  end

  // One extra bit holds the rounded sum of two full-scale samples.
  logic [DATA_W:0]   cb_sum;
  logic [DATA_W:0]   cr_sum;
  logic [DATA_W-1:0] cb_avg;
  logic [DATA_W-1:0] cr_avg;

  assign cb_sum = {1'b0, cb0} + {1'b0, Cb_in} + (DATA_W+1)'(1);
  assign cr_sum = {1'b0, cr0} + {1'b0, Cr_in} + (DATA_W+1)'(1);
  assign cb_avg = DATA_W'(cb_sum >> 1);
  assign cr_avg = DATA_W'(cr_sum >> 1);

  logic              pend_valid;
  logic [DATA_W-1:0] pend_y;
  logic [DATA_W-1:0] pend_c;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      pend_valid <= 1'b0;
      pend_y     <= '0;
      pend_c     <= '0;
    end else begin
      pend_valid <= pair;
      if (pair) begin
        pend_y <= Y_in;
        pend_c <= cr_avg;
      end
    end
  end

  // A pair never directly follows a pair, so the two sources never collide.
  logic          push;
  logic [WW-1:0] push_word;

  always_comb begin
    push      = 1'b0;
    push_word = '0;
    unique case (1'b1)
      pair: begin
        push      = 1'b1;
        push_word = {1'b0, y0, cb_avg};
      end
      pend_valid: begin
        push      = 1'b1;
        push_word = {1'b1, pend_y, pend_c};
      end
      default: begin
        push      = 1'b0;
        push_word = '0;
      end
    endcase
  end

  logic [WW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          full;
  logic          pop;
  logic          push_ok;
  logic [WW-1:0] head;

  assign full      = (fifo_level == LW'(FIFO_DEPTH));
  assign out_valid = (fifo_level != '0);
  assign pop       = out_valid && out_ready;
  assign push_ok   = push && (!full || pop);

  always_ff @(posedge Clock) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_word;
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      overflow   <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push_ok, pop})
        2'b10:   fifo_level <= fifo_level + LW'(1);
        2'b01:   fifo_level <= fifo_level - LW'(1);
        default: fifo_level <= fifo_level;
      endcase
      if (push && full && !pop) begin
        overflow <= 1'b1;
      end
    end
  end

  assign head      = out_valid ? mem[rd_ptr] : '0;
  assign out_is_cr = head[WW-1];
  assign out_data  = head[WW-2:0];

endmodule

// File: tb/tb_yuv444_to_422.sv
// Directed bench for yuv444_to_422 with a queue-level reference model.
// Each cycle the DUT FIFO head, level and overflow are compared to the model.
module tb_yuv444_to_422;

  localparam int W = 10;
  localparam int D = 8;

  typedef logic [2*W:0] word_t;

  logic         Clock = 1'b0;
  logic         Reset = 1'b0;
  logic [W-1:0] y_in  = '0;
  logic [W-1:0] cb_in = '0;
  logic [W-1:0] cr_in = '0;
  logic         dv    = 1'b0;
  logic         ls    = 1'b0;
  logic         rdy   = 1'b1;
  logic [2*W-1:0] out_data;
  logic         out_is_cr;
  logic         out_valid;
  logic [$clog2(D):0] fifo_level;
  logic         overflow;

  bit tog = 1'b0;

  yuv444_to_422 #(.DATA_W(W), .FIFO_DEPTH(D)) dut (
    .Clock        (Clock),
    .Reset        (Reset),
    .Y_in         (y_in),
    .Cb_in        (cb_in),
    .Cr_in        (cr_in),
    .data_valid_in(dv),
    .line_start   (ls),
    .out_data     (out_data),
    .out_is_cr    (out_is_cr),
    .out_valid    (out_valid),
    .out_ready    (rdy),
    .fifo_level   (fifo_level),
    .overflow     (overflow)
  );

  always #5 Clock = ~Clock;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: held pixel, one deferred Cr word, bounded word queue.
  word_t mq[$];
  word_t m_pend = '0;
  bit    m_pend_v = 1'b0;
  bit    m_held_v = 1'b0;
  int    hy = 0, hcb = 0, hcr = 0;
  bit    m_ovf = 1'b0;

  function automatic void model_step();
    bit    pop;
    bit    has_push;
    bit    new_pend;
    word_t w;
    word_t w1;
    pop      = rdy && (mq.size() > 0);
    has_push = 1'b0;
    new_pend = 1'b0;
    w        = '0;
    w1       = '0;
    if (m_pend_v) begin
      has_push = 1'b1;
      w        = m_pend;
    end
    if (dv) begin
      if (ls || !m_held_v) begin
        hy = int'(y_in); hcb = int'(cb_in); hcr = int'(cr_in);
        m_held_v = 1'b1;
      end else begin
        has_push = 1'b1;
        w  = {1'b0, W'(hy), W'((hcb + int'(cb_in) + 1) / 2)};
        w1 = {1'b1, y_in,   W'((hcr + int'(cr_in) + 1) / 2)};
        new_pend = 1'b1;
        m_held_v = 1'b0;
      end
    end
    if (pop) void'(mq.pop_front());
    if (has_push) begin
      if (mq.size() < D) mq.push_back(w);
      else m_ovf = 1'b1;
    end
    m_pend_v = new_pend;
    m_pend   = w1;
  endfunction

  always begin
    @(posedge Clock or negedge Reset);
    if (!Reset) begin
      mq.delete();
      m_pend_v = 1'b0;
      m_held_v = 1'b0;
      m_ovf    = 1'b0;
    end else begin
      model_step();
    end
  end

  word_t plog[$];

  always @(negedge Clock) begin
    chk("valid", 32'(out_valid), 32'(mq.size() > 0));
    chk("level", 32'(fifo_level), 32'(mq.size()));
    chk("ovf", 32'(overflow), 32'(m_ovf));
    if (mq.size() > 0) chk("head", 32'({out_is_cr, out_data}), 32'(mq[0]));
    if (out_valid && rdy) plog.push_back({out_is_cr, out_data});
  end

  task automatic tick();
    @(posedge Clock);
    #1;
    if (tog) rdy = ~rdy;
  endtask

  task automatic pix(input int y, input int cb, input int cr, input bit l);
    y_in  = W'(y);
    cb_in = W'(cb);
    cr_in = W'(cr);
    dv    = 1'b1;
    ls    = l;
    tick();
    dv = 1'b0;
    ls = 1'b0;
  endtask

  function automatic word_t wd(input bit c, input int y, input int v);
    return {c, W'(y), W'(v)};
  endfunction

  task automatic chk_zero(input string nm);
    chk({nm, "_valid"}, 32'(out_valid), 0);
    chk({nm, "_data"}, 32'(out_data), 0);
    chk({nm, "_iscr"}, 32'(out_is_cr), 0);
    chk({nm, "_level"}, 32'(fifo_level), 0);
    chk({nm, "_ovf"}, 32'(overflow), 0);
  endtask

  task automatic chk_log(input string nm, input int idx, input word_t exp);
    if (plog.size() > idx) chk(nm, 32'(plog[idx]), 32'(exp));
    else chk({nm, "_missing"}, 32'(plog.size()), 32'(idx + 1));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    #3;
    chk_zero("reset");
    @(posedge Clock);
    #1;
    Reset = 1'b1;
    tick();

    // Basic pair, latency of both words
    pix(100, 200, 300, 1'b1);
    pix(110, 201, 305, 1'b0);
    chk("lat_w0_valid", 32'(out_valid), 1);
    chk("lat_w0", 32'({out_is_cr, out_data}), 32'(wd(0, 100, 201)));
    tick();
    chk("lat_w1", 32'({out_is_cr, out_data}), 32'(wd(1, 110, 303)));
    tick();
    chk("drained", 32'(out_valid), 0);

    // Full-scale and minimum rounding
    pix(7, 1023, 1023, 1'b0);
    pix(8, 1023, 1023, 1'b0);
    chk("max_cb", 32'({out_is_cr, out_data}), 32'(wd(0, 7, 1023)));
    tick();
    chk("max_cr", 32'({out_is_cr, out_data}), 32'(wd(1, 8, 1023)));
    pix(3, 0, 0, 1'b0);
    pix(4, 1, 1, 1'b0);
    chk("min_cb", 32'({out_is_cr, out_data}), 32'(wd(0, 3, 1)));
    tick();
    chk("min_cr", 32'({out_is_cr, out_data}), 32'(wd(1, 4, 1)));
    tick();

    // line_start discards an unpaired pixel
    plog.delete();
    pix(50, 60, 70, 1'b0);
    pix(80, 90, 100, 1'b1);
    pix(82, 94, 104, 1'b0);
    repeat (3) tick();
    chk("ls_count", 32'(plog.size()), 2);
    chk_log("ls_w0", 0, wd(0, 80, 92));
    chk_log("ls_w1", 1, wd(1, 82, 102));
    chk("ls_ovf", 32'(overflow), 0);

    // Overflow with a stalled sink
    rdy = 1'b0;
    plog.delete();
    for (int i = 0; i < 10; i++) pix(i*10 + 5, i*4, 1000 - i*3, 1'b0);
    repeat (2) tick();
    chk("ovf_level", 32'(fifo_level), 8);
    chk("ovf_flag", 32'(overflow), 1);
    rdy = 1'b1;
    repeat (12) tick();
    chk("ovf_count", 32'(plog.size()), 8);
    chk_log("ovf_first", 0, wd(0, 5, 2));
    chk_log("ovf_last", 7, wd(1, 75, 981));
    chk("ovf_sticky", 32'(overflow), 1);

    Reset = 1'b0;
    tick();
    Reset = 1'b1;
    chk("ovf_cleared", 32'(overflow), 0);

    // Toggling ready with continuous input
    plog.delete();
    rdy = 1'b1;
    tog = 1'b1;
    for (int i = 0; i < 12; i++) pix(i*7 + 1, i*80, 1023 - i*60, 1'b0);
    repeat (20) tick();
    tog = 1'b0;
    rdy = 1'b1;
    chk("tog_count", 32'(plog.size()), 12);
    chk("tog_ovf", 32'(overflow), 0);
    for (int k = 0; k < 6; k++) begin
      chk_log("tog_cb", 2*k,
              wd(0, 14*k + 1, (160*k + 160*k + 80 + 1) / 2));
      chk_log("tog_cr", 2*k + 1,
              wd(1, 14*k + 8, ((1023 - 120*k) + (963 - 120*k) + 1) / 2));
    end

    // Reset mid-pair with three queued words
    rdy = 1'b0;
    pix(1, 2, 3, 1'b0);
    pix(4, 5, 6, 1'b0);
    rdy = 1'b1;
    tick();
    rdy = 1'b0;
    pix(7, 8, 9, 1'b0);
    pix(10, 11, 12, 1'b0);
    pix(13, 14, 15, 1'b0);
    chk("pre_rst_level", 32'(fifo_level), 3);
    Reset = 1'b0;
    #1;
    chk_zero("async_rst");
    tick();
    chk_zero("held_rst");
    Reset = 1'b1;
    plog.delete();
    rdy = 1'b1;
    pix(200, 10, 20, 1'b0);
    pix(210, 30, 40, 1'b0);
    repeat (3) tick();
    chk("post_rst_count", 32'(plog.size()), 2);
    chk_log("post_rst_w0", 0, wd(0, 200, 20));
    chk_log("post_rst_w1", 1, wd(1, 210, 30));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
